y_row_fetch_seq: RTL and testbench
==================================

// Module: y_row_fetch_seq
// PURPOSE
//  Sequences Y-matrix row fetches for the change-in-Y path. Accepts one row number per
//  request from the change.txt stream and reads the row-pointer line at row>>4. It
//  extracts the 11-bit start address of the row, then reads two consecutive 256-bit
//  data lines at addr and addr+1. Sits between the change-entry FIFO and the single
//  read port of the Y SRAM, and returns both lines to the update datapath.
// PARAMETERS
//  RD_LAT  2    SRAM read latency in cycles (data valid RD_LAT cycles after mem_rd_en), >=1
//  ADDR_W  11   SRAM line address width
//  DATA_W  256  SRAM line width; holds 16 pointer fields of 16 bits each
// PORTS
//  clock        in   1       system clock
//  reset        in   1       asynchronous, active-low reset
//  req_valid    in   1       request row number valid
//  req_ready    out  1       block can accept a request
//  req_row      in   16      Y row number
//  mem_rd_en    out  1       SRAM read strobe, one cycle per read
//  mem_rd_addr  out  ADDR_W  SRAM read address
//  mem_rd_data  in   DATA_W  SRAM read data
//  out_valid    out  1       result valid; held until out_ready
//  out_ready    in   1       consumer accepts result
//  out_addr     out  ADDR_W  start address of fetched row (11'h7FF when empty or error)
//  out_line0    out  DATA_W  data line at out_addr
//  out_line1    out  DATA_W  data line at out_addr+1
//  out_empty    out  1       pointer was 11'h7FF (row has no entries); lines are zero
//  out_err      out  1       req_row[15]=1 (pointer line out of range); no SRAM access
//  busy         out  1       FSM not in IDLE
// BEHAVIOUR
//  Reset (async, active-low): FSM->IDLE; req_ready=1; mem_rd_en=0; mem_rd_addr=11'h7FF;
//   out_valid=0; out_addr=11'h7FF; out_line0/1=0; out_empty=0; out_err=0; busy=0.
//   Reads already in flight are discarded, and their returning data is never captured.
//  FSM: IDLE -> PTR_RD -> PTR_WAIT -> DAT_RD0 -> DAT_RD1 -> DAT_WAIT -> OUT -> IDLE.
//  IDLE: req_ready=1. A request is accepted when req_valid&req_ready (cycle 0), and
//   req_row is latched. If req_row[15]=1 -> OUT with out_err=1, no read.
//  PTR_RD (cycle 1): mem_rd_en=1, mem_rd_addr=req_row[14:4].
//  PTR_WAIT: a down-counter loaded with RD_LAT runs. mem_rd_data is sampled at the end of
//   cycle 1+RD_LAT. ptr = data[16*k+10 : 16*k], k=req_row[3:0]; bits [16*k+15:16*k+11]
//   are ignored. If ptr==11'h7FF -> OUT with out_empty=1 and zero lines.
//  DAT_RD0 (cycle 2+RD_LAT): mem_rd_en=1, addr=ptr.
//  DAT_RD1 (cycle 3+RD_LAT): mem_rd_en=1, addr=ptr+1. The addition is modulo 2^ADDR_W, so
//   ptr=11'h7FE reads 7FE then 7FF. Reads are back-to-back, with no bubble.
//  DAT_WAIT: line0 is captured at the end of cycle 2+2*RD_LAT, line1 at 3+2*RD_LAT.
//  OUT: out_valid=1 from cycle 4+2*RD_LAT (cycle 8 for RD_LAT=2). Outputs stay stable
//   until out_valid&out_ready; out_valid drops the next cycle and the FSM returns to IDLE.
//  Outside PTR_RD/DAT_RD0/DAT_RD1: mem_rd_en=0, and mem_rd_addr holds its last value.
//  Early exits: the error path shows out_valid at cycle 1; the empty path at cycle 2+RD_LAT.
//  Only one request is outstanding. req_ready=0 in every state except IDLE, including
//   the OUT cycle in which the result is accepted. The next request is accepted earliest
//   the cycle after the FSM re-enters IDLE.
//  out_ready asserted while out_valid=0 is ignored. out_empty and out_err are never both 1.
// TESTING
//  T1 reset: hold reset=0 with random inputs -> all outputs at their reset values,
//     req_ready=1.
//  T2 normal: req_row=16'h0023, pointer line 2 field 3=11'h100, out_ready=1 -> reads at
//     002/100/101 in cycles 1/4/5, out_valid in cycle 8, lines match addresses 100/101.
//  T3 empty: pointer field=11'h7FF -> single read, out_valid cycle 4, out_empty=1,
//     lines=0, out_addr=7FF.
//  T4 error: req_row=16'h8000 -> no mem_rd_en, out_err=1, out_valid in cycle 1.
//  T5 backpressure/wrap: ptr=11'h7FE, out_ready low for 5 cycles -> reads 7FE,7FF;
//     outputs stable while out_ready is low; req_ready low until the cycle after the
//     handshake.
//  T6 reset mid-op: assert reset during DAT_WAIT -> reset values; the late read data
//     is ignored; the next request completes correctly.

Source files
------------

// File: rtl/y_row_fetch_seq.sv
// -----------------------------------------------------------------------------
// y_row_fetch_seq
//
// Purpose:
//   Fetches one Y-matrix row for the change-in-Y path. For each accepted row
//   number, the block reads the pointer line at row>>4. It extracts the 11-bit
//   start address from field row[3:0], then reads the two consecutive data
//   lines at addr and addr+1. Both lines go to the update datapath.
//   Only one request is in flight at a time. The SRAM has a fixed read latency
//   of RD_LAT cycles.
//
// Ports:
//   clock        in   1       system clock
//   reset        in   1       asynchronous, active-low reset
//   req_valid    in   1       request row number valid
//   req_ready    out  1       block can accept a request (only in IDLE)
//   req_row      in   16      Y row number; bit 15 set marks an out-of-range row
//   mem_rd_en    out  1       SRAM read strobe, one cycle per read
//   mem_rd_addr  out  ADDR_W  SRAM read address (holds between reads)
//   mem_rd_data  in   DATA_W  SRAM read data, valid RD_LAT cycles after strobe
//   out_valid    out  1       result valid, held until out_ready
//   out_ready    in   1       consumer accepts result
//   out_addr     out  ADDR_W  start address of the row (all ones if empty/error)
//   out_line0    out  DATA_W  data line at out_addr
//   out_line1    out  DATA_W  data line at out_addr+1
//   out_empty    out  1       row pointer was all ones; lines are zero
//   out_err      out  1       row number out of range; no SRAM access made
//   busy         out  1       sequencer not idle
// -----------------------------------------------------------------------------
module y_row_fetch_seq #(
    parameter int RD_LAT = 2,
    parameter int ADDR_W = 11,
    parameter int DATA_W = 256
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [15:0]       req_row,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_line0,
    output logic [DATA_W-1:0] out_line1,
    output logic              out_empty,
    output logic              out_err,
    output logic              busy
);

    // Pointer value meaning "row has no entries"; also the idle/error address.
    localparam logic [ADDR_W-1:0] NULL_PTR = '1;
    localparam int                CNT_W    = $clog2(RD_LAT + 1) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PTR_RD,
        S_PTR_WAIT,
        S_DAT_RD0,
        S_DAT_RD1,
        S_DAT_WAIT,
        S_OUT
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [3:0]          r_k;
    logic                r_req_ready;
    logic                r_mem_rd_en;
    logic [ADDR_W-1:0]   r_mem_rd_addr;
    logic                r_out_valid;
    logic [ADDR_W-1:0]   r_out_addr;
    logic [DATA_W-1:0]   r_out_line0;
    logic [DATA_W-1:0]   r_out_line1;
    logic                r_out_empty;
    logic                r_out_err;
    logic                r_busy;

    logic [ADDR_W-1:0]   w_ptr;
    logic                w_accept;
    logic                w_line0_take;

    assign w_accept = req_valid && r_req_ready;

    // Field select within the pointer line. Only the low ADDR_W bits of each
    // 16-bit field carry the address; the upper bits are ignored.
    always_comb begin
        w_ptr = '0;
        for (int k = 0; k < 16; k++) begin
            if (r_k == 4'(k)) begin
                w_ptr = mem_rd_data[16*k +: ADDR_W];
            end
        end
    end

    // line0 returns one cycle before line1. When RD_LAT is 1, it arrives while
    // the second data read is still being issued (DAT_RD1). Otherwise it lands
    // in DAT_WAIT one count before line1.
    assign w_line0_take = ((r_state == S_DAT_RD1) && (RD_LAT == 1)) ||
                          ((r_state == S_DAT_WAIT) && (r_cnt == CNT_W'(2)));

    // Field index of the accepted request. It is data only and needs no reset.
    always_ff @(posedge clock) begin
        if (w_accept && (r_state == S_IDLE)) begin
            r_k <= req_row[3:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_req_ready   <= 1'b1;
            r_mem_rd_en   <= 1'b0;
            r_mem_rd_addr <= NULL_PTR;
            r_out_valid   <= 1'b0;
            r_out_addr    <= NULL_PTR;
            r_out_line0   <= '0;
            r_out_line1   <= '0;
            r_out_empty   <= 1'b0;
            r_out_err     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            if (w_line0_take) begin
                r_out_line0 <= mem_rd_data;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_out_addr  <= NULL_PTR;
                        r_out_line0 <= '0;
                        r_out_line1 <= '0;
                        r_out_empty <= 1'b0;
                        r_out_err   <= 1'b0;
                        if (req_row[15]) begin
                            // Pointer line lies beyond the table; report
                            // without touching the SRAM.
                            r_out_err   <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= S_OUT;
                        end else begin
                            r_mem_rd_en   <= 1'b1;
                            r_mem_rd_addr <= ADDR_W'(req_row[14:4]);
                            r_state       <= S_PTR_RD;
                        end
                    end
                end

                S_PTR_RD: begin
                    r_mem_rd_en <= 1'b0;
                    r_cnt       <= CNT_W'(RD_LAT);
                    r_state     <= S_PTR_WAIT;
                end

                S_PTR_WAIT: begin
                    // The count reaches 1 in the cycle the pointer line is on
                    // the bus.
                    if (r_cnt == CNT_W'(1)) begin
                        r_out_addr <= w_ptr;
                        if (w_ptr == NULL_PTR) begin
                            r_out_empty <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= S_OUT;
                        end else begin
                            r_mem_rd_en   <= 1'b1;
                            r_mem_rd_addr <= w_ptr;
                            r_state       <= S_DAT_RD0;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                S_DAT_RD0: begin
                    // Back-to-back second read. The increment wraps modulo the
                    // address space.
                    r_mem_rd_addr <= r_mem_rd_addr + ADDR_W'(1);
                    r_state       <= S_DAT_RD1;
                end

                S_DAT_RD1: begin
                    r_mem_rd_en <= 1'b0;
                    r_cnt       <= CNT_W'(RD_LAT);
                    r_state     <= S_DAT_WAIT;
                end

                S_DAT_WAIT: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_out_line1 <= mem_rd_data;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign mem_rd_en   = r_mem_rd_en;
    assign mem_rd_addr = r_mem_rd_addr;
    assign out_valid   = r_out_valid;
    assign out_addr    = r_out_addr;
    assign out_line0   = r_out_line0;
    assign out_line1   = r_out_line1;
    assign out_empty   = r_out_empty;
    assign out_err     = r_out_err;
    assign busy        = r_busy;

endmodule

// File: tb/tb_y_row_fetch_seq.sv
// -----------------------------------------------------------------------------
// tb_y_row_fetch_seq
//
// Scoreboard bench for y_row_fetch_seq. A behavioural SRAM with RD_LAT latency
// drives random junk whenever no read is returning. The stimulus computes each
// expected result and read trace from the memory image and queues them. Two
// monitors compare the DUT against those queues.
// -----------------------------------------------------------------------------
module tb_y_row_fetch_seq;

    localparam int RD_LAT = 2;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 256;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [15:0]       req_row = 16'h0;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_line0;
    logic [DATA_W-1:0] out_line1;
    logic              out_empty;
    logic              out_err;
    logic              busy;

    always #5 clock = ~clock;

    y_row_fetch_seq #(.RD_LAT(RD_LAT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_row(req_row),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_line0(out_line0), .out_line1(out_line1),
        .out_empty(out_empty), .out_err(out_err), .busy(busy)
    );

    // ---------------- SRAM model ----------------
    logic [DATA_W-1:0] mem [2048];
    logic              pv  [RD_LAT];
    logic [ADDR_W-1:0] pa  [RD_LAT];
    logic [DATA_W-1:0] junk;

    always @(posedge clock) begin
        pv[0] <= mem_rd_en;
        pa[0] <= mem_rd_addr;
        for (int i = 1; i < RD_LAT; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
        end
        for (int i = 0; i < 8; i++) junk[32*i +: 32] <= $urandom;
    end

    assign mem_rd_data = pv[RD_LAT-1] ? mem[pa[RD_LAT-1]] : junk;

    // ---------------- bookkeeping ----------------
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] l0;
        logic [DATA_W-1:0] l1;
        logic              empty;
        logic              err;
        int                acc;
        int                lat;
    } exp_t;

    typedef struct {
        logic [ADDR_W-1:0] a;
        int                c;
    } rd_t;

    exp_t exq[$];
    rd_t  rdq[$];
    exp_t cur;
    logic have = 1'b0;
    logic expect_idle = 1'b0;
    logic [ADDR_W-1:0] last_rd_addr = 11'h7FF;

    int or_mode = 1;
    int lowcnt  = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: the result follows directly from the row number and the
    // memory image.
    function automatic exp_t model(input logic [15:0] row);
        exp_t e;
        logic [DATA_W-1:0] pl;
        logic [ADDR_W-1:0] p, pn;
        int k;
        e.addr = 11'h7FF; e.l0 = '0; e.l1 = '0; e.empty = 1'b0; e.err = 1'b0;
        e.acc = 0; e.lat = 0;
        if (row[15]) begin
            e.err = 1'b1; e.lat = 1;
            return e;
        end
        pl = mem[row[14:4]];
        k  = int'(row[3:0]);
        p  = pl[16*k +: 11];
        if (p == 11'h7FF) begin
            e.empty = 1'b1; e.lat = 2 + RD_LAT;
            return e;
        end
        pn = p + 11'd1;
        e.addr = p; e.l0 = mem[p]; e.l1 = mem[pn]; e.lat = 4 + 2*RD_LAT;
        return e;
    endfunction

    task automatic set_field(input logic [15:0] row, input logic [10:0] p);
        logic [DATA_W-1:0] l;
        int k;
        l = mem[row[14:4]];
        k = int'(row[3:0]);
        l[16*k +: 16] = {5'($urandom), p};
        mem[row[14:4]] = l;
    endtask

    task automatic issue(input logic [15:0] row, output int acc);
        exp_t e;
        rd_t  r;
        int   g;
        acc = -1;
        @(negedge clock);
        req_valid = 1'b1;
        req_row   = row;
        g = 0;
        while (!req_ready && g < 300) begin
            @(negedge clock);
            g++;
        end
        chk("req_accept", 256'(req_ready), 256'(1'b1));
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        acc   = cyc;
        e     = model(row);
        e.acc = acc;
        exq.push_back(e);
        if (!row[15]) begin
            r.a = row[14:4]; r.c = acc + 1; rdq.push_back(r);
            if (!e.empty) begin
                r.a = e.addr;         r.c = acc + 2 + RD_LAT; rdq.push_back(r);
                r.a = e.addr + 11'd1; r.c = acc + 3 + RD_LAT; rdq.push_back(r);
            end
        end
        @(negedge clock);
        req_valid = 1'b0;
        req_row   = 16'($urandom);
    endtask

    task automatic wait_idle();
        int   g;
        logic ok;
        g = 0;
        while ((exq.size() != 0 || have || !req_ready) && g < 500) begin
            @(negedge clock);
            g++;
        end
        ok = (exq.size() == 0) && !have && req_ready;
        chk("idle_reached", 256'(ok), 256'(1'b1));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req_ready"},   256'(req_ready),   256'(1'b1));
        chk({tag, "_mem_rd_en"},   256'(mem_rd_en),   256'(1'b0));
        chk({tag, "_mem_rd_addr"}, 256'(mem_rd_addr), 256'(11'h7FF));
        chk({tag, "_out_valid"},   256'(out_valid),   256'(1'b0));
        chk({tag, "_out_addr"},    256'(out_addr),    256'(11'h7FF));
        chk({tag, "_out_line0"},   out_line0,         256'(0));
        chk({tag, "_out_line1"},   out_line1,         256'(0));
        chk({tag, "_out_empty"},   256'(out_empty),   256'(1'b0));
        chk({tag, "_out_err"},     256'(out_err),     256'(1'b0));
        chk({tag, "_busy"},        256'(busy),        256'(1'b0));
    endtask

    // ---------------- out_ready driver ----------------
    initial begin
        forever begin
            @(posedge clock);
            #1;
            case (or_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    if (out_valid) begin
                        if (lowcnt < 5) begin
                            out_ready = 1'b0;
                            lowcnt++;
                        end else begin
                            out_ready = 1'b1;
                        end
                    end else begin
                        out_ready = 1'b0;
                    end
                end
            endcase
        end
    end

    // ---------------- output monitor ----------------
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                if (expect_idle) begin
                    chk("post_hs_out_valid", 256'(out_valid), 256'(1'b0));
                    chk("post_hs_req_ready", 256'(req_ready), 256'(1'b1));
                    chk("post_hs_busy",      256'(busy),      256'(1'b0));
                    expect_idle = 1'b0;
                end
                if (out_valid) begin
                    if (!have) begin
                        if (exq.size() == 0) begin
                            chk("unexpected_out_valid", 256'(out_valid), 256'(1'b0));
                        end else begin
                            cur  = exq.pop_front();
                            have = 1'b1;
                            chk("out_latency", 256'(cyc - cur.acc), 256'(cur.lat));
                        end
                    end
                    if (have) begin
                        chk("out_addr",      256'(out_addr),  256'(cur.addr));
                        chk("out_line0",     out_line0,       cur.l0);
                        chk("out_line1",     out_line1,       cur.l1);
                        chk("out_empty",     256'(out_empty), 256'(cur.empty));
                        chk("out_err",       256'(out_err),   256'(cur.err));
                        chk("req_ready_out", 256'(req_ready), 256'(1'b0));
                        chk("busy_out",      256'(busy),      256'(1'b1));
                        if (out_ready) begin
                            have        = 1'b0;
                            expect_idle = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // ---------------- read-port monitor ----------------
    initial begin
        rd_t r;
        forever begin
            @(negedge clock);
            if (reset) begin
                if (mem_rd_en) begin
                    if (rdq.size() == 0) begin
                        chk("unexpected_rd", 256'(mem_rd_en), 256'(1'b0));
                    end else begin
                        r = rdq.pop_front();
                        chk("rd_addr",  256'(mem_rd_addr), 256'(r.a));
                        chk("rd_cycle", 256'(cyc),         256'(r.c));
                    end
                    last_rd_addr = mem_rd_addr;
                end else begin
                    chk("rd_addr_hold", 256'(mem_rd_addr), 256'(last_rd_addr));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int acc;
        logic [31:0] rnd;
        logic [15:0] row;
        int sel;

        for (int a = 0; a < 2048; a++)
            for (int i = 0; i < 8; i++) mem[a][32*i +: 32] = $urandom;

        // T1: reset held with random inputs
        for (int n = 0; n < 6; n++) begin
            @(posedge clock);
            #1;
            req_valid = 1'($urandom);
            req_row   = 16'($urandom);
            @(negedge clock);
            check_reset_vals("reset");
        end
        #1;
        req_valid = 1'b0;
        reset     = 1'b1;

        or_mode = 0;

        // T2: normal fetch
        set_field(16'h0023, 11'h100);
        issue(16'h0023, acc);
        wait_idle();

        // T3: empty row, then T4: error row immediately after
        set_field(16'h0457, 11'h7FF);
        issue(16'h0457, acc);
        issue(16'h8000, acc);
        wait_idle();

        // T5: wrap at top of address space under backpressure
        set_field(16'h1230, 11'h7FE);
        lowcnt  = 0;
        or_mode = 2;
        issue(16'h1230, acc);
        wait_idle();
        or_mode = 0;

        // T6: reset while data reads are returning
        set_field(16'h0ABC, 11'h3C5);
        issue(16'h0ABC, acc);
        while (cyc < acc + 3 + RD_LAT) @(negedge clock);
        @(posedge clock);
        #2;
        reset = 1'b0;
        exq.delete();
        rdq.delete();
        have         = 1'b0;
        expect_idle  = 1'b0;
        last_rd_addr = 11'h7FF;
        @(negedge clock);
        check_reset_vals("midreset");
        #1;
        reset = 1'b1;
        @(negedge clock);
        chk("late_line0_ignored", out_line0, 256'(0));
        chk("late_line1_ignored", out_line1, 256'(0));
        chk("late_valid",         256'(out_valid), 256'(1'b0));
        issue(16'h0ABC, acc);
        wait_idle();

        // Random traffic with random consumer backpressure
        or_mode = 1;
        for (int n = 0; n < 40; n++) begin
            rnd = $urandom;
            row = rnd[15:0];
            sel = $urandom_range(0, 7);
            row[15] = (sel == 0);
            if (sel == 1) begin
                wait_idle();
                set_field(row, 11'h7FF);
            end else if (sel == 2) begin
                wait_idle();
                set_field(row, 11'h7FE);
            end
            issue(row, acc);
        end
        wait_idle();
        repeat (RD_LAT + 2) @(negedge clock);
        chk("exq_drained", 256'(exq.size()), 256'(0));
        chk("rdq_drained", 256'(rdq.size()), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
